// File: rtl/tcdm_resp_pkg.sv
// Shared types and helpers for the TCDM memory responder.
package tcdm_resp_pkg;

    localparam int TCDM_DW  = 32;
    localparam int TCDM_BEW = 4;

    // One in-flight response: whether it exists, whether it returns SRAM
    // read data, and whether it is an error response.
    typedef struct packed {
        logic valid;
        logic is_read;
        logic err;
    } resp_slot_t;

    // Address window check done in 33 bits so base + span cannot wrap.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span_bytes
    );
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + span_bytes;
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Fixed-depth response shift register; depth equals the SRAM read latency
// so the head slot lines up with the SRAM read data.
module tcdm_resp_pipe
    import tcdm_resp_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       srst,
    input  resp_slot_t push_slot,
    output resp_slot_t head_slot
);

    resp_slot_t chain [LATENCY+1];

    assign chain[0] = push_slot;

    for (genvar gi = 0; gi < LATENCY; gi++) begin : gen_stage
        resp_slot_t slot_reg;

        // Advance one stage per cycle; clearing drops everything in flight.
        always_ff @(posedge clk) begin
            if (srst) begin
                slot_reg <= '0;
            end else begin
                slot_reg <= chain[gi];
            end
        end

        assign chain[gi+1] = slot_reg;
    end

    assign head_slot = chain[LATENCY];

endmodule

// File: rtl/tcdm_mem_responder.sv
// TCDM slave endpoint: grants requests, drives a single-port SRAM and
// returns one in-order response per grant after a fixed latency.
module tcdm_mem_responder
    import tcdm_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 1,
    parameter int          ERR_CNT_W = 16,
    localparam int         AW        = $clog2(MEM_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic [31:0]          add_i,
    input  logic                 wen_i,
    input  logic [TCDM_DW-1:0]   wdata_i,
    input  logic [TCDM_BEW-1:0]  be_i,
    output logic                 gnt_o,
    output logic                 r_valid_o,
    output logic [TCDM_DW-1:0]   r_rdata_o,
    output logic                 r_opc_o,
    input  logic                 stall_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [TCDM_DW-1:0]   mem_wdata_o,
    output logic [TCDM_BEW-1:0]  mem_be_o,
    input  logic [TCDM_DW-1:0]   mem_rdata_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam logic [32:0] SPAN_BYTES = 33'(MEM_WORDS) << 2;

    logic       grant;
    logic       accept;
    logic       in_range;
    resp_slot_t push_slot;
    resp_slot_t head_slot;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    // Grant is combinational; reset and a busy bank both withhold it.
    assign grant    = req_i & ~stall_i & ~rst_i;
    assign accept   = req_i & grant;
    assign in_range = addr_in_range(add_i, BASE_ADDR, SPAN_BYTES);
    assign gnt_o    = grant;

    // SRAM port is a straight pass-through; only in-range accepts enable it.
    // BASE_ADDR is word-aligned, so the word index needs only bits [AW+1:2].
    assign mem_req_o   = accept & in_range;
    assign mem_we_o    = ~wen_i;
    assign mem_addr_o  = add_i[AW+1:2] - BASE_ADDR[AW+1:2];
    assign mem_wdata_o = wdata_i;
    assign mem_be_o    = be_i;

    // Every accept takes a slot, errors included, so responses stay ordered.
    assign push_slot = '{valid:   accept,
                         is_read: accept & wen_i,
                         err:     accept & ~in_range};

    tcdm_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk_i),
        .srst      (rst_i),
        .push_slot (push_slot),
        .head_slot (head_slot)
    );

    // Only successful reads return SRAM data; writes and errors return zero.
    assign r_valid_o = head_slot.valid;
    assign r_opc_o   = head_slot.valid & head_slot.err;
    assign r_rdata_o = (head_slot.valid & head_slot.is_read & ~head_slot.err)
                       ? mem_rdata_i : '0;

    // Saturating count of error responses handed back to the master.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_reg <= '0;
        end else if (r_valid_o && r_opc_o && !(&err_cnt_reg)) begin
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    assign err_cnt_o = err_cnt_reg;

endmodule

// File: doc/tcdm_mem_responder.md
# tcdm_mem_responder

Slave-side endpoint of the XBAR_TCDM_BUS req/gnt/r_valid protocol that the FC core drives on its instruction and data ports. It turns granted TCDM requests into single-port SRAM accesses with a fixed, parameterisable read latency. It returns exactly one in-order response per granted request, for reads and writes alike. Out-of-range addresses get an error response on `r_opc`. It sits between the SoC interconnect and a private L2 bank or scratchpad macro.

## Interface
- `BASE_ADDR`, 32'h1C00_0000: byte address of word 0.
- `MEM_WORDS`, 4096: bank depth in 32-bit words; power of two.
- `LATENCY`, 1: SRAM read latency in cycles (1..4); also the request-to-response latency.
- `ERR_CNT_W`, 16: width of the error counter.
- `clk_i`  in  1  sole clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  TCDM request.
- `add_i`  in  32  byte address.
- `wen_i`  in  1  1 = read, 0 = write.
- `wdata_i`  in  32  write data.
- `be_i`  in  4  byte enables.
- `gnt_o`  out  1  grant; same-cycle.
- `r_valid_o`  out  1  response valid; one per grant.
- `r_rdata_o`  out  32  read data.
- `r_opc_o`  out  1  1 = error response.
- `stall_i`  in  1  bank busy (retention/maintenance); blocks grants.
- `mem_req_o`  out  1  SRAM enable.
- `mem_we_o`  out  1  SRAM write enable.
- `mem_addr_o`  out  $clog2(MEM_WORDS)  word address.
- `mem_wdata_o`  out  32  SRAM write data.
- `mem_be_o`  out  4  SRAM byte mask.
- `mem_rdata_i`  in  32  SRAM read data, valid `LATENCY` cycles after a read enable.
- `err_cnt_o`  out  ERR_CNT_W  saturating count of error responses.

## Operation
- `gnt_o = req_i & ~stall_i & ~rst_i`. A request is accepted when `req_i & gnt_o`. One acceptance is possible per cycle, fully pipelined.
- In-range test: `BASE_ADDR <= add_i < BASE_ADDR + 4*MEM_WORDS`.
  - Word index = `(add_i - BASE_ADDR) >> 2`. Bits [1:0] are ignored.
- Accepted in-range request: `mem_req_o` = 1 in the same cycle.
  - `mem_we_o = ~wen_i`; address, data and byte enables are passed straight through.
- Accepted out-of-range request: `mem_req_o` = 0 and no SRAM side effect. The request still consumes one pipeline slot so that responses stay in order.
- Response pipeline is a `LATENCY`-deep shift register. Each slot holds {valid, is_read, err}. It is filled on acceptance and shifted every cycle.
- At pipeline output:
  - `r_valid_o` = valid.
  - `r_opc_o` = valid & err.
  - `r_rdata_o` = `mem_rdata_i` if valid & is_read & ~err, otherwise 0.
- Writes produce `r_valid_o` with `r_rdata_o` = 0.
- `err_cnt_o` increments on every cycle with `r_valid_o & r_opc_o` and saturates at all-ones.
- `stall_i` only blocks new grants. Responses already in flight drain normally.

## Timing
- Reset values: `gnt_o` 0, `r_valid_o` 0, `r_opc_o` 0, `r_rdata_o` 0, `mem_req_o` 0, `err_cnt_o` 0, all pipeline slots invalid.
- Accept in cycle T gives the response in cycle T+`LATENCY` exactly.
  - No back-pressure exists on responses, since TCDM has no r_ready.
- Back-to-back accepts in T, T+1, T+2 give responses in T+L, T+L+1, T+L+2, in acceptance order.
- `stall_i` high in cycle T: `gnt_o` = 0 in T. A request held by the master is granted in the first cycle with `stall_i` low.
- Reset asserted mid-operation: in-flight responses are dropped, with no `r_valid_o` from the cycle after `rst_i` is sampled. `err_cnt_o` is cleared.
- Address at the last word (`BASE_ADDR + 4*MEM_WORDS - 4`) is in range; `BASE_ADDR + 4*MEM_WORDS` is an error.
  - The comparison is done in 33 bits so `BASE_ADDR + 4*MEM_WORDS` cannot wrap.
- Error counter at saturation stays at all-ones and does not wrap.

## Structure
- Package `tcdm_resp_pkg`:
  - slot typedef `resp_slot_t` {valid, is_read, err};
  - `TCDM_DW`=32 and `TCDM_BEW`=4 constants;
  - in-range check function.
- Sub-module `tcdm_resp_pipe`: parameterised `LATENCY`-deep shift register of `resp_slot_t` with synchronous clear.
- Top level: grant/decode logic, SRAM port drive, output mux, error counter.

## Test plan
- `LATENCY`=1, write 32'hDEAD_BEEF with be=4'hF to 0x1C00_0010, then read the same address → write response in T+1 with rdata 0 and opc 0; read response rdata 32'hDEAD_BEEF one cycle after its grant.
- `LATENCY`=3, four back-to-back reads of words 0..3 preloaded with 1,2,3,4 → `gnt_o` high in 4 consecutive cycles; responses 1,2,3,4 in cycles T+3..T+6.
- Read of 0x1C00_4000 (one past the end, `MEM_WORDS`=4096) → `mem_req_o` never asserted; response with opc=1, rdata 0; `err_cnt_o` = 1.
- `stall_i` high for 5 cycles while `req_i` is held → `gnt_o` 0 throughout; grant in the cycle `stall_i` falls; a response issued before the stall still arrives on schedule.
- `LATENCY`=2, grant a read, then assert `rst_i` in the following cycle → no `r_valid_o` from the cycle after reset is sampled; all outputs at their reset values.
- `ERR_CNT_W`=4, 17 error accesses → `err_cnt_o` holds at 4'hF.
